// File: rtl/cpu_reg_dump_if.sv
// Byte stream channel from the register dumper to a UART or capture sink.
// The master presents out_data/out_valid and the slave answers with out_ready.
interface cpu_reg_dump_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/cpu_reg_dump.sv
// Snapshots the cpu register file on a halted rising edge and streams it as a
// framed byte sequence: header, (index, data MSB first) per register, XOR checksum.
module cpu_reg_dump #(
    parameter int         NUM_REGS    = 8,
    parameter int         REG_WIDTH   = 16,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          halted,
    input  logic [NUM_REGS*REG_WIDTH-1:0] debug_reg_state,
    cpu_reg_dump_if.master                stream,
    output logic                          busy,
    output logic                          done
);

    localparam int SNAP_W = NUM_REGS * REG_WIDTH;
    localparam int BYTES  = REG_WIDTH / 8;
    localparam int BW     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int SEL_W  = $clog2(SNAP_W);

    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);
    localparam logic [7:0]    LAST_REG  = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_INDEX  = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Byte byte_idx of register reg_idx, counting from the most significant byte.
    function automatic logic [7:0] snap_byte(
        input logic [SNAP_W-1:0] snap,
        input logic [7:0]        reg_idx,
        input logic [BW-1:0]     byte_idx
    );
        logic [31:0] base_v;
        base_v = 32'(reg_idx) * 32'(REG_WIDTH)
               + (32'(BYTES - 1) - 32'(byte_idx)) * 32'd8;
        return snap[base_v[SEL_W-1:0] +: 8];
    endfunction

    function automatic logic [7:0] csum_fold(
        input logic [7:0] acc,
        input logic [7:0] data_byte
    );
        return acc ^ data_byte;
    endfunction

    state_t              state_r;
    logic [SNAP_W-1:0]   snapshot_r;
    logic [7:0]          checksum_r;
    logic [7:0]          reg_idx_r;
    logic [BW-1:0]       byte_idx_r;
    logic                halted_q_r;
    logic [7:0]          out_data_r;
    logic                out_valid_r;
    logic                busy_r;
    logic                done_r;

    logic                xfer_s;
    logic                rise_s;
    logic [7:0]          csum_next_s;
    logic [7:0]          data_first_s;
    logic [7:0]          data_next_s;

    // Handshake, edge detect and the candidate next bytes for the FSM.
    always_comb begin
        xfer_s       = out_valid_r && stream.out_ready;
        rise_s       = halted && !halted_q_r;
        csum_next_s  = csum_fold(checksum_r, out_data_r);
        data_first_s = snap_byte(snapshot_r, reg_idx_r, {BW{1'b0}});
        data_next_s  = snap_byte(snapshot_r, reg_idx_r, byte_idx_r + BW'(1));
    end

    // Frame sequencer; the byte for the next state is loaded on the same edge
    // as the transition so out_data/out_valid stay registered.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r     <= ST_IDLE;
            snapshot_r  <= {SNAP_W{1'b0}};
            checksum_r  <= 8'd0;
            reg_idx_r   <= 8'd0;
            byte_idx_r  <= {BW{1'b0}};
            halted_q_r  <= 1'b0;
            out_data_r  <= 8'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            halted_q_r <= halted;
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (rise_s) begin
                        snapshot_r  <= debug_reg_state;
                        checksum_r  <= 8'd0;
                        reg_idx_r   <= 8'd0;
                        byte_idx_r  <= {BW{1'b0}};
                        out_data_r  <= HEADER_BYTE;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_HEADER;
                    end else begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                ST_HEADER: begin
                    if (xfer_s) begin
                        out_data_r <= reg_idx_r;
                        state_r    <= ST_INDEX;
                    end else begin
                        state_r    <= ST_HEADER;
                    end
                end
                ST_INDEX: begin
                    if (xfer_s) begin
                        checksum_r <= csum_next_s;
                        byte_idx_r <= {BW{1'b0}};
                        out_data_r <= data_first_s;
                        state_r    <= ST_DATA;
                    end else begin
                        state_r    <= ST_INDEX;
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        checksum_r <= csum_next_s;
                        if (byte_idx_r != LAST_BYTE) begin
                            byte_idx_r <= byte_idx_r + BW'(1);
                            out_data_r <= data_next_s;
                        end else if (reg_idx_r != LAST_REG) begin
                            reg_idx_r  <= reg_idx_r + 8'd1;
                            out_data_r <= reg_idx_r + 8'd1;
                            state_r    <= ST_INDEX;
                        end else begin
                            // csum_next_s already folds in this final data byte.
                            out_data_r <= csum_next_s;
                            state_r    <= ST_CHECK;
                        end
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_CHECK: begin
                    if (xfer_s) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r     <= ST_CHECK;
                    end
                end
                ST_DONE: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    if (!halted) begin
                        done_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign stream.out_data  = out_data_r;
    assign stream.out_valid = out_valid_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule

// File: tb/tb_cpu_reg_dump.sv
// Randomised scoreboard bench for cpu_reg_dump: default 8x16 instance plus a 2x8 corner instance.
module tb_cpu_reg_dump;

    typedef logic [7:0] bq_t[$];

    logic         clk;
    logic         rst_n;
    logic         halted_a;
    logic         halted_b;
    logic [127:0] regs_a;
    logic [15:0]  regs_b;
    logic         busy_a, done_a, busy_b, done_b;

    cpu_reg_dump_if bus_a();
    cpu_reg_dump_if bus_b();

    cpu_reg_dump dut_a (
        .CLK(clk), .RESET_N(rst_n), .halted(halted_a), .debug_reg_state(regs_a),
        .stream(bus_a), .busy(busy_a), .done(done_a)
    );

    cpu_reg_dump #(.NUM_REGS(2), .REG_WIDTH(8), .HEADER_BYTE(8'hA5)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .halted(halted_b), .debug_reg_state(regs_b),
        .stream(bus_b), .busy(busy_b), .done(done_b)
    );

    int         checks = 0;
    int         errors = 0;
    int         ready_mode = 0;
    int         xfer_a = 0;
    logic [7:0] last_a = 8'd0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference frame: header, then per register its index and bytes MSB first, then XOR of all but header.
    function automatic bq_t make_frame(input logic [63:0] vals[$], input int nbytes);
        bq_t        f;
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'd0;
        f.push_back(8'hA5);
        for (int i = 0; i < vals.size(); i++) begin
            b = 8'(i);
            f.push_back(b);
            cs ^= b;
            for (int k = nbytes - 1; k >= 0; k--) begin
                b = 8'(vals[i] >> (8 * k));
                f.push_back(b);
                cs ^= b;
            end
        end
        f.push_back(cs);
        return f;
    endfunction

    task automatic push_a();
        logic [63:0] v[$];
        bq_t         f;
        for (int i = 0; i < 8; i++) v.push_back(64'(regs_a[i*16 +: 16]));
        f = make_frame(v, 2);
        foreach (f[j]) exp_a.push_back(f[j]);
    endtask

    task automatic push_b();
        logic [63:0] v[$];
        bq_t         f;
        for (int i = 0; i < 2; i++) v.push_back(64'(regs_b[i*8 +: 8]));
        f = make_frame(v, 1);
        foreach (f[j]) exp_b.push_back(f[j]);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frame_a(output int cycles);
        cycles = 0;
        while (exp_a.size() != 0 && cycles < 600) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        if (exp_a.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_a_timeout actual=%0d bytes left required=0", exp_a.size());
            exp_a.delete();
        end
    endtask

    task automatic wait_frame_b(output int cycles);
        cycles = 0;
        while (exp_b.size() != 0 && cycles < 200) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        if (exp_b.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_b_timeout actual=%0d bytes left required=0", exp_b.size());
            exp_b.delete();
        end
    endtask

    // Sink ready driver: always ready, 1,0,0,1 pattern, or random.
    initial begin
        int cnt;
        cnt = 0;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus_a.out_ready = 1'b1;
                1:       bus_a.out_ready = ((cnt % 4) == 0) || ((cnt % 4) == 3);
                default: bus_a.out_ready = 1'($urandom_range(0, 1));
            endcase
            bus_b.out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cnt++;
        end
    end

    // Monitor A: pops the scoreboard on each transfer, checks stall stability.
    initial begin
        logic       stall_q;
        logic [7:0] stall_d;
        logic [7:0] e;
        stall_q = 1'b0;
        stall_d = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    chk("stall_valid_a", 64'(bus_a.out_valid), 64'd1);
                    chk("stall_data_a", 64'(bus_a.out_data), 64'(stall_d));
                end
                chk("busy_vs_valid_a", 64'(busy_a), 64'(bus_a.out_valid));
                if (bus_a.out_valid && bus_a.out_ready) begin
                    if (exp_a.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte_a actual=%0h required=none", bus_a.out_data);
                    end else begin
                        e = exp_a.pop_front();
                        chk("byte_a", 64'(bus_a.out_data), 64'(e));
                    end
                    last_a  = bus_a.out_data;
                    xfer_a++;
                    stall_q = 1'b0;
                end else if (bus_a.out_valid) begin
                    stall_q = 1'b1;
                    stall_d = bus_a.out_data;
                end else begin
                    stall_q = 1'b0;
                end
            end
        end
    end

    // Monitor B: corner-parameter instance.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("busy_vs_valid_b", 64'(busy_b), 64'(bus_b.out_valid));
                if (bus_b.out_valid && bus_b.out_ready) begin
                    if (exp_b.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte_b actual=%0h required=none", bus_b.out_data);
                    end else begin
                        e = exp_b.pop_front();
                        chk("byte_b", 64'(bus_b.out_data), 64'(e));
                    end
                end
            end
        end
    end

    initial begin
        int cyc;
        int x0;
        rst_n    = 1'b0;
        halted_a = 1'b0;
        halted_b = 1'b0;
        regs_a   = 128'd0;
        regs_b   = 16'd0;
        #12;
        chk("reset_valid", 64'(bus_a.out_valid), 64'd0);
        chk("reset_data", 64'(bus_a.out_data), 64'd0);
        chk("reset_busy", 64'(busy_a), 64'd0);
        chk("reset_done", 64'(done_a), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Basic dump at full rate.
        ready_mode = 0;
        regs_a = 128'd0;
        regs_a[15:0] = 16'h1234;
        push_a();
        halted_a = 1'b1;
        wait_frame_a(cyc);
        chk("basic_cycles", 64'(cyc), 64'd27);
        chk("basic_done", 64'(done_a), 64'd1);
        chk("basic_valid_low", 64'(bus_a.out_valid), 64'd0);
        chk("basic_checksum", 64'(last_a), 64'h26);
        halted_a = 1'b0;
        tick(2);

        // Backpressure 1,0,0,1 with a halted glitch mid-frame that must not restart.
        ready_mode = 1;
        x0 = xfer_a;
        push_a();
        halted_a = 1'b1;
        tick(10);
        halted_a = 1'b0;
        tick(2);
        halted_a = 1'b1;
        wait_frame_a(cyc);
        tick(5);
        chk("bp_done_held", 64'(done_a), 64'd1);
        chk("bp_valid_low", 64'(bus_a.out_valid), 64'd0);
        chk("bp_byte_count", 64'(xfer_a - x0), 64'd26);
        halted_a = 1'b0;
        tick(2);

        // Snapshot isolation: trash the inputs after the header.
        ready_mode = 0;
        push_a();
        halted_a = 1'b1;
        cyc = 0;
        while (exp_a.size() > 25 && cyc < 50) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        regs_a   = {8{16'hFFFF}};
        halted_a = 1'b0;
        wait_frame_a(cyc);
        chk("iso_done", 64'(done_a), 64'd1);
        @(posedge clk);
        #2;
        chk("iso_idle_done", 64'(done_a), 64'd0);
        chk("iso_idle_busy", 64'(busy_a), 64'd0);
        tick(1);

        // Re-arm with reg3 = BEEF.
        regs_a = 128'd0;
        regs_a[3*16 +: 16] = 16'hBEEF;
        push_a();
        halted_a = 1'b1;
        wait_frame_a(cyc);
        chk("rearm_checksum", 64'(last_a), 64'h51);
        chk("rearm_done", 64'(done_a), 64'd1);
        halted_a = 1'b0;
        tick(2);

        // Random register files under random backpressure.
        for (int r = 0; r < 6; r++) begin
            ready_mode = 2;
            regs_a = {$urandom, $urandom, $urandom, $urandom};
            push_a();
            halted_a = 1'b1;
            wait_frame_a(cyc);
            chk("rand_done_a", 64'(done_a), 64'd1);
            halted_a = 1'b0;
            tick(2);
        end

        // Asynchronous reset during DATA of reg 2, halted left high.
        ready_mode = 0;
        regs_a = {$urandom, $urandom, $urandom, $urandom};
        push_a();
        halted_a = 1'b1;
        cyc = 0;
        while (exp_a.size() > 18 && cyc < 50) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy_a), 64'd0);
        chk("rst_mid_done", 64'(done_a), 64'd0);
        exp_a.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_a();
        wait_frame_a(cyc);
        chk("rst_restart_cycles", 64'(cyc), 64'd27);
        chk("rst_restart_done", 64'(done_a), 64'd1);
        halted_a = 1'b0;
        tick(2);

        // Corner instance: 2 regs of 8 bits.
        regs_b = {8'hF0, 8'h0F};
        exp_b.push_back(8'hA5);
        exp_b.push_back(8'h00);
        exp_b.push_back(8'h0F);
        exp_b.push_back(8'h01);
        exp_b.push_back(8'hF0);
        exp_b.push_back(8'hFE);
        halted_b = 1'b1;
        wait_frame_b(cyc);
        chk("corner_cycles", 64'(cyc), 64'd7);
        chk("corner_done", 64'(done_b), 64'd1);
        halted_b = 1'b0;
        tick(2);
        for (int r = 0; r < 4; r++) begin
            ready_mode = 2;
            regs_b = 16'($urandom);
            push_b();
            halted_b = 1'b1;
            wait_frame_b(cyc);
            chk("rand_done_b", 64'(done_b), 64'd1);
            halted_b = 1'b0;
            tick(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
